compare_serial: RTL

Parametrised multi-cycle magnitude comparator for the ConfusedCore hmmm datapath. It generalises the zero-comparator to arbitrary WIDTH, to comparison against a second operand or against zero, and to signed or unsigned compare. Operands are latched on a start handshake and compared MSB-first, CHUNK bits per cycle. A done pulse marks the result. The block serves the branch/compare unit wherever a narrow, low-area compare path is acceptable.

---
 rtl/compare_serial.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/compare_serial.sv
// Multi-cycle MSB-first magnitude comparator: CHUNK bits per cycle, signed/unsigned, A vs B or A vs 0.
// Optional macro COMPARE_SERIAL_EARLY_EXIT_EN finishes on the first differing chunk instead of after N cycles.
module compare_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             zero_mode,
  input  logic             signed_cmp,
  output logic             busy,
  output logic             done,
  output logic [1:0]       comp
);

  localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
  localparam int N          = WIDTH / CHUNK_SAFE;
  localparam int IDX_W      = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  generate
    if ((CHUNK < 1) || ((WIDTH % CHUNK_SAFE) != 0) || (N < 1)) begin : g_bad_cfg
      $fatal(1, "compare_serial: CHUNK must be >= 1 and divide WIDTH exactly");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Handshake: start is accepted on a rising edge where busy==0; done is a
  // one-cycle pulse and comp stays valid from that cycle until the next completion.
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             signed_q, signed_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             decided_q, decided_d;
  logic             gt_q, gt_d;
  logic [1:0]       comp_q, comp_d;
  logic             done_q, done_d;

  logic [CHUNK_SAFE-1:0] chunk_a, chunk_b;
  logic                  chunk_differ, chunk_gt;
  logic                  decided_now, gt_now, finish;

  // Chunk select; in signed mode the sign bit is flipped so an unsigned compare orders correctly.
  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IDX_W'(i)) begin
        chunk_a = a_q[i*CHUNK_SAFE +: CHUNK_SAFE];
        chunk_b = b_q[i*CHUNK_SAFE +: CHUNK_SAFE];
      end
    end
    if (signed_q && (idx_q == LAST_IDX)) begin
      chunk_a[CHUNK_SAFE-1] = ~chunk_a[CHUNK_SAFE-1];
      chunk_b[CHUNK_SAFE-1] = ~chunk_b[CHUNK_SAFE-1];
    end
  end

  assign chunk_differ = (chunk_a != chunk_b);
  assign chunk_gt     = (chunk_a > chunk_b);
  assign decided_now  = decided_q | chunk_differ;
  assign gt_now       = decided_q ? gt_q : chunk_gt;

`ifdef COMPARE_SERIAL_EARLY_EXIT_EN
  assign finish = (idx_q == '0) || chunk_differ;
`else
  assign finish = (idx_q == '0);
`endif

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    signed_d  = signed_q;
    idx_d     = idx_q;
    decided_d = decided_q;
    gt_d      = gt_q;
    comp_d    = comp_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d       = a;
          b_d       = zero_mode ? '0 : b;
          signed_d  = signed_cmp;
          idx_d     = LAST_IDX;
          decided_d = 1'b0;
          gt_d      = 1'b0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        decided_d = decided_now;
        gt_d      = gt_now;
        idx_d     = idx_q - IDX_W'(1);
        if (finish) begin
          state_d = IDLE;
          done_d  = 1'b1;
          comp_d  = decided_now ? {1'b0, gt_now} : 2'b10;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      signed_q  <= 1'b0;
      idx_q     <= '0;
      decided_q <= 1'b0;
      gt_q      <= 1'b0;
      comp_q    <= 2'b00;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      signed_q  <= signed_d;
      idx_q     <= idx_d;
      decided_q <= decided_d;
      gt_q      <= gt_d;
      comp_q    <= comp_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q == BUSY);
  assign done = done_q;
  assign comp = comp_q;

endmodule
